page_fault_handler: RTL and testbench

Sequencer between the MMU fault path and the page frame allocator.
- Accepts a faulting VPN and requests a frame from the allocator.
- On out-of-memory, evicts a victim frame chosen by a FIFO/clock hand: invalidates its PTE and TLB entry, returns the frame, then retries.
- Writes the new valid PTE and returns completion to the MMU.
- Keeps a frame→VPN owner map for victim lookup.

---
 rtl/page_fault_handler.sv | 135 +++++++++++++
 tb/tb_page_fault_handler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/page_fault_handler.sv
// page_fault_handler: sequences page faults through frame allocation, FIFO eviction and PTE/TLB updates
module page_fault_handler #(
  parameter int NUM_FRAMES = 256,
  parameter int FRAME_BITS = 8,
  parameter int VPN_BITS   = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fault_valid,
  output logic                  fault_ready,
  input  logic [VPN_BITS-1:0]   fault_vpn,
  output logic                  alloc_req,
  input  logic                  alloc_valid,
  input  logic [FRAME_BITS-1:0] alloc_frame,
  input  logic                  out_of_memory,
  output logic                  dealloc_req,
  output logic [FRAME_BITS-1:0] dealloc_frame,
  input  logic                  dealloc_valid,
  output logic                  pt_wr_en,
  output logic [VPN_BITS-1:0]   pt_wr_vpn,
  output logic [FRAME_BITS-1:0] pt_wr_frame,
  output logic                  pt_wr_present,
  output logic                  tlb_inv_en,
  output logic [VPN_BITS-1:0]   tlb_inv_vpn,
  output logic                  done_valid,
  input  logic                  done_ready,
  output logic [FRAME_BITS-1:0] done_frame,
  output logic                  done_error,
  output logic [15:0]           evict_count
);
  typedef enum logic [2:0] {IDLE, ALLOC, EVICT_INV, EVICT_FREE, MAP, DONE} state_t;
  state_t                  state_q, state_d;
  logic [VPN_BITS-1:0]     vpn_q, vpn_d;
  logic [FRAME_BITS-1:0]   frame_q, frame_d;
  logic [FRAME_BITS-1:0]   hand_q, hand_d;
  logic [FRAME_BITS-1:0]   scan_q, scan_d;
  logic                    err_q, err_d;
  logic [15:0]             evict_q, evict_d;
  logic [NUM_FRAMES-1:0]   owner_valid_q, owner_valid_d;
  logic [VPN_BITS-1:0]     owner_q [NUM_FRAMES];
  logic                    owner_we;
  logic [FRAME_BITS-1:0]   hand_inc;
  logic                    victim_hit;
  logic                    map_st;
  assign hand_inc   = (hand_q == FRAME_BITS'(NUM_FRAMES - 1)) ? '0 : hand_q + FRAME_BITS'(1);
  assign victim_hit = (state_q == EVICT_INV) && owner_valid_q[hand_q];
  assign map_st     = (state_q == MAP);
  // next-state and datapath update for the fault sequence
  always_comb begin
    state_d       = state_q;
    vpn_d         = vpn_q;
    frame_d       = frame_q;
    hand_d        = hand_q;
    scan_d        = scan_q;
    err_d         = err_q;
    evict_d       = evict_q;
    owner_valid_d = owner_valid_q;
    owner_we      = 1'b0;
    case (state_q)
      IDLE: if (fault_valid) begin
        vpn_d   = fault_vpn;
        err_d   = 1'b0;
        state_d = ALLOC;
      end
      ALLOC: if (alloc_valid) begin
        frame_d                    = alloc_frame;
        owner_we                   = 1'b1;
        owner_valid_d[alloc_frame] = 1'b1;
        state_d                    = MAP;
      end else if (out_of_memory) begin
        scan_d  = '0;
        state_d = EVICT_INV;
      end
      EVICT_INV: if (owner_valid_q[hand_q]) begin
        state_d = EVICT_FREE;
      end else begin
        hand_d = hand_inc;
        scan_d = scan_q + FRAME_BITS'(1);
        if (scan_q == FRAME_BITS'(NUM_FRAMES - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      EVICT_FREE: begin
        owner_valid_d[hand_q] = 1'b0;
        hand_d                = hand_inc;
        state_d               = ALLOC;
        evict_d               = (dealloc_valid && evict_q != 16'hFFFF) ? evict_q + 16'd1 : evict_q;
      end
      MAP:     state_d = DONE;
      DONE:    state_d = done_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset drops any in-flight fault without touching the page table
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      vpn_q         <= '0;
      frame_q       <= '0;
      hand_q        <= '0;
      scan_q        <= '0;
      err_q         <= 1'b0;
      evict_q       <= '0;
      owner_valid_q <= '0;
    end else begin
      state_q       <= state_d;
      vpn_q         <= vpn_d;
      frame_q       <= frame_d;
      hand_q        <= hand_d;
      scan_q        <= scan_d;
      err_q         <= err_d;
      evict_q       <= evict_d;
      owner_valid_q <= owner_valid_d;
    end
  end
  // frame-to-VPN owner map; contents only meaningful where owner_valid is set
  always_ff @(posedge clk) begin
    if (owner_we) owner_q[alloc_frame] <= vpn_q;
  end
  assign fault_ready   = (state_q == IDLE);
  assign alloc_req     = (state_q == ALLOC);
  assign dealloc_req   = (state_q == EVICT_FREE);
  assign dealloc_frame = dealloc_req ? hand_q : '0;
  assign pt_wr_en      = victim_hit || map_st;
  assign pt_wr_vpn     = victim_hit ? owner_q[hand_q] : map_st ? vpn_q : '0;
  assign pt_wr_frame   = victim_hit ? hand_q : map_st ? frame_q : '0;
  assign pt_wr_present = map_st;
  assign tlb_inv_en    = victim_hit;
  assign tlb_inv_vpn   = victim_hit ? owner_q[hand_q] : '0;
  assign done_valid    = (state_q == DONE);
  assign done_frame    = (done_valid && !err_q) ? frame_q : '0;
  assign done_error    = done_valid && err_q;
  assign evict_count   = evict_q;
endmodule

// File: tb/tb_page_fault_handler.sv
// tb_page_fault_handler: vector table plus scoreboard checks against a small allocator model
module tb_page_fault_handler;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        fault_valid, fault_ready;
  logic [19:0] fault_vpn;
  logic        alloc_req, alloc_valid, out_of_memory;
  logic [1:0]  alloc_frame;
  logic        dealloc_req, dealloc_valid;
  logic [1:0]  dealloc_frame;
  logic        pt_wr_en, pt_wr_present;
  logic [19:0] pt_wr_vpn;
  logic [1:0]  pt_wr_frame;
  logic        tlb_inv_en;
  logic [19:0] tlb_inv_vpn;
  logic        done_valid, done_ready, done_error;
  logic [1:0]  done_frame;
  logic [15:0] evict_count;
  page_fault_handler #(.NUM_FRAMES(4), .FRAME_BITS(2), .VPN_BITS(20)) dut (
    .clk(clk), .rst_n(rst_n), .fault_valid(fault_valid), .fault_ready(fault_ready),
    .fault_vpn(fault_vpn), .alloc_req(alloc_req), .alloc_valid(alloc_valid),
    .alloc_frame(alloc_frame), .out_of_memory(out_of_memory), .dealloc_req(dealloc_req),
    .dealloc_frame(dealloc_frame), .dealloc_valid(dealloc_valid), .pt_wr_en(pt_wr_en),
    .pt_wr_vpn(pt_wr_vpn), .pt_wr_frame(pt_wr_frame), .pt_wr_present(pt_wr_present),
    .tlb_inv_en(tlb_inv_en), .tlb_inv_vpn(tlb_inv_vpn), .done_valid(done_valid),
    .done_ready(done_ready), .done_frame(done_frame), .done_error(done_error),
    .evict_count(evict_count)
  );
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction
  function automatic void unexpected(input string name, input logic [31:0] act);
    n_chk++;
    n_fail++;
    $display("FAIL %s: unexpected event value 0x%0h, none expected", name, act);
  endfunction
  logic [3:0] used;
  logic       fill;
  always_comb begin
    alloc_frame = 2'd0;
    for (int i = 3; i >= 0; i--) if (!used[i]) alloc_frame = 2'(i);
    out_of_memory = (used == 4'hF);
    alloc_valid   = alloc_req && (used != 4'hF);
    dealloc_valid = dealloc_req && used[dealloc_frame];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) used <= '0;
    else if (fill) used <= 4'hF;
    else begin
      if (alloc_valid) used[alloc_frame] <= 1'b1;
      if (dealloc_valid) used[dealloc_frame] <= 1'b0;
    end
  end
  typedef struct packed {logic [19:0] vpn; logic [1:0] frame; logic present;} pt_t;
  typedef struct packed {logic [1:0] frame; logic err;} done_t;
  pt_t         pt_q[$];
  logic [19:0] tlb_q[$];
  logic [1:0]  dl_q[$];
  done_t       done_q[$];
  always @(negedge clk) begin
    if (rst_n) begin
      if (alloc_req && dealloc_req) unexpected("alloc_and_dealloc_same_cycle", 32'd1);
      if (pt_wr_en) begin
        if (pt_q.size() == 0) unexpected("pt_write", 32'({pt_wr_vpn, pt_wr_frame, pt_wr_present}));
        else chk("pt_write", 32'({pt_wr_vpn, pt_wr_frame, pt_wr_present}), 32'(pt_q.pop_front()));
      end
      if (tlb_inv_en) begin
        if (tlb_q.size() == 0) unexpected("tlb_inv", 32'(tlb_inv_vpn));
        else chk("tlb_inv", 32'(tlb_inv_vpn), 32'(tlb_q.pop_front()));
      end
      if (dealloc_req) begin
        if (dl_q.size() == 0) unexpected("dealloc", 32'(dealloc_frame));
        else chk("dealloc", 32'(dealloc_frame), 32'(dl_q.pop_front()));
      end
      if (done_valid && done_ready) begin
        if (done_q.size() == 0) unexpected("done", 32'({done_frame, done_error}));
        else chk("done", 32'({done_frame, done_error}), 32'(done_q.pop_front()));
      end
    end
  end
  typedef struct {
    logic [19:0] vpn;
    logic [1:0]  frame;
    logic        err;
    logic        vic;
    logic [19:0] vvpn;
    logic [1:0]  vframe;
    int          lat;
    int          evict;
  } vec_t;
  vec_t tbl[9];
  task automatic do_reset();
    rst_n = 1'b0;
    fault_valid = 1'b0;
    done_ready = 1'b1;
    fill = 1'b0;
    #1;
    pt_q.delete();
    tlb_q.delete();
    dl_q.delete();
    done_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic push_victim(input vec_t v);
    pt_q.push_back({v.vvpn, v.vframe, 1'b0});
    tlb_q.push_back(v.vvpn);
    dl_q.push_back(v.vframe);
  endtask
  task automatic run(input vec_t v);
    int cyc;
    chk("fault_ready_idle", 32'(fault_ready), 32'd1);
    if (v.vic) push_victim(v);
    if (!v.err) pt_q.push_back({v.vpn, v.frame, 1'b1});
    done_q.push_back({v.err ? 2'd0 : v.frame, v.err});
    fault_vpn = v.vpn;
    fault_valid = 1'b1;
    done_ready = 1'b1;
    @(posedge clk);
    #1 fault_valid = 1'b0;
    cyc = 1;
    chk("alloc_req_after_accept", 32'(alloc_req), 32'd1);
    chk("fault_ready_busy", 32'(fault_ready), 32'd0);
    while (!done_valid && cyc < 100) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk("done_latency", 32'(cyc), 32'(v.lat));
    @(posedge clk);
    #1;
    chk("evict_count", 32'(evict_count), 32'(v.evict));
    chk("fault_ready_after_done", 32'(fault_ready), 32'd1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t v;
    int cyc;
    tbl[0] = '{20'h10, 2'd0, 1'b0, 1'b0, 20'h0,  2'd0, 3, 0};
    tbl[1] = '{20'h11, 2'd1, 1'b0, 1'b0, 20'h0,  2'd0, 3, 0};
    tbl[2] = '{20'h12, 2'd2, 1'b0, 1'b0, 20'h0,  2'd0, 3, 0};
    tbl[3] = '{20'h13, 2'd3, 1'b0, 1'b0, 20'h0,  2'd0, 3, 0};
    tbl[4] = '{20'h14, 2'd0, 1'b0, 1'b1, 20'h10, 2'd0, 6, 1};
    tbl[5] = '{20'h15, 2'd1, 1'b0, 1'b1, 20'h11, 2'd1, 6, 2};
    tbl[6] = '{20'h16, 2'd2, 1'b0, 1'b1, 20'h12, 2'd2, 6, 3};
    tbl[7] = '{20'h17, 2'd3, 1'b0, 1'b1, 20'h13, 2'd3, 6, 4};
    tbl[8] = '{20'h18, 2'd0, 1'b0, 1'b1, 20'h14, 2'd0, 6, 5};
    fault_vpn = '0;
    rst_n = 1'b0;
    fault_valid = 1'b0;
    done_ready = 1'b1;
    fill = 1'b0;
    #1;
    chk("rst_fault_ready", 32'(fault_ready), 32'd1);
    chk("rst_alloc_req", 32'(alloc_req), 32'd0);
    chk("rst_pt_wr_en", 32'(pt_wr_en), 32'd0);
    chk("rst_done_valid", 32'(done_valid), 32'd0);
    chk("rst_evict_count", 32'(evict_count), 32'd0);
    do_reset();
    run('{20'h00012, 2'd0, 1'b0, 1'b0, 20'h0, 2'd0, 3, 0});
    do_reset();
    for (int i = 0; i < 9; i++) run(tbl[i]);
    v = '{20'h30, 2'd1, 1'b0, 1'b1, 20'h15, 2'd1, 6, 6};
    push_victim(v);
    pt_q.push_back({20'h30, 2'd1, 1'b1});
    done_q.push_back({2'd1, 1'b0});
    fault_vpn = 20'h30;
    fault_valid = 1'b1;
    done_ready = 1'b0;
    @(posedge clk);
    #1 fault_vpn = 20'h31;
    cyc = 1;
    while (!done_valid && cyc < 100) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk("hold_latency", 32'(cyc), 32'd6);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("hold_done_valid", 32'(done_valid), 32'd1);
      chk("hold_done_frame", 32'(done_frame), 32'd1);
      chk("hold_fault_ready", 32'(fault_ready), 32'd0);
    end
    done_ready = 1'b1;
    fault_valid = 1'b0;
    chk("release_fault_ready_same_cycle", 32'(fault_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("release_fault_ready_next", 32'(fault_ready), 32'd1);
    chk("release_done_valid", 32'(done_valid), 32'd0);
    chk("hold_evict_count", 32'(evict_count), 32'd6);
    do_reset();
    fill = 1'b1;
    @(posedge clk);
    #1 fill = 1'b0;
    run('{20'h99, 2'd0, 1'b1, 1'b0, 20'h0, 2'd0, 6, 0});
    do_reset();
    for (int i = 0; i < 4; i++) run('{20'h40 + 20'(i), 2'(i), 1'b0, 1'b0, 20'h0, 2'd0, 3, 0});
    v = '{20'h44, 2'd0, 1'b0, 1'b1, 20'h40, 2'd0, 6, 1};
    push_victim(v);
    fault_vpn = 20'h44;
    fault_valid = 1'b1;
    @(posedge clk);
    #1 fault_valid = 1'b0;
    cyc = 1;
    while (!dealloc_req && cyc < 100) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk("evict_free_reached", 32'(cyc), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("async_rst_fault_ready", 32'(fault_ready), 32'd1);
    chk("async_rst_dealloc_req", 32'(dealloc_req), 32'd0);
    chk("async_rst_dealloc_frame", 32'(dealloc_frame), 32'd0);
    chk("async_rst_pt_wr_en", 32'(pt_wr_en), 32'd0);
    chk("async_rst_done_valid", 32'(done_valid), 32'd0);
    chk("async_rst_evict_count", 32'(evict_count), 32'd0);
    do_reset();
    chk("post_rst_fault_ready", 32'(fault_ready), 32'd1);
    run('{20'h45, 2'd0, 1'b0, 1'b0, 20'h0, 2'd0, 3, 0});
    chk("pt_queue_drained", 32'(pt_q.size()), 32'd0);
    chk("tlb_queue_drained", 32'(tlb_q.size()), 32'd0);
    chk("dealloc_queue_drained", 32'(dl_q.size()), 32'd0);
    chk("done_queue_drained", 32'(done_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
